idma_reg32_3d_launcher: RTL and testbench



---
 rtl/idma_reg32_3d_launcher_pkg.sv | 89 ++++++++
 rtl/idma_reg32_3d_launcher.sv | 183 ++++++++++++++++++
 tb/tb_idma_reg32_3d_launcher.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_reg32_3d_launcher_pkg.sv
// Shared types, register offsets and the write-order table for the
// idma_reg32_3d launcher.
package idma_reg32_3d_launcher_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg32_rsp_t;

    typedef struct packed {
        logic [31:0] conf;
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] length;
        logic [31:0] src_stride_2;
        logic [31:0] dst_stride_2;
        logic [31:0] reps_2;
        logic [31:0] src_stride_3;
        logic [31:0] dst_stride_3;
        logic [31:0] reps_3;
        logic [3:0]  stream;
        logic        wait_done;
    } job_t;

    typedef struct packed {
        logic [31:0] id;
        logic        err;
    } res_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WRITE    = 3'd1;
    localparam state_t ST_LAUNCH   = 3'd2;
    localparam state_t ST_POLL_GAP = 3'd3;
    localparam state_t ST_POLL     = 3'd4;
    localparam state_t ST_RESULT   = 3'd5;

    // Mirrors the register map of the idma_reg32_3d frontend.
    localparam logic [31:0] CONF_OFFSET             = 32'h0000_0000;
    localparam logic [31:0] NEXT_ID_0_OFFSET        = 32'h0000_0044;
    localparam logic [31:0] DONE_ID_0_OFFSET        = 32'h0000_0084;
    localparam logic [31:0] DST_ADDR_LOW_OFFSET     = 32'h0000_00D0;
    localparam logic [31:0] SRC_ADDR_LOW_OFFSET     = 32'h0000_00D8;
    localparam logic [31:0] LENGTH_LOW_OFFSET       = 32'h0000_00E0;
    localparam logic [31:0] DST_STRIDE_2_LOW_OFFSET = 32'h0000_00E8;
    localparam logic [31:0] SRC_STRIDE_2_LOW_OFFSET = 32'h0000_00F0;
    localparam logic [31:0] REPS_2_LOW_OFFSET       = 32'h0000_00F8;
    localparam logic [31:0] DST_STRIDE_3_LOW_OFFSET = 32'h0000_0100;
    localparam logic [31:0] SRC_STRIDE_3_LOW_OFFSET = 32'h0000_0108;
    localparam logic [31:0] REPS_3_LOW_OFFSET       = 32'h0000_0110;

    localparam int unsigned NumWrites = 10;

    localparam logic [31:0] WriteSeq [NumWrites] = '{
        CONF_OFFSET, SRC_ADDR_LOW_OFFSET, DST_ADDR_LOW_OFFSET, LENGTH_LOW_OFFSET,
        SRC_STRIDE_2_LOW_OFFSET, DST_STRIDE_2_LOW_OFFSET, REPS_2_LOW_OFFSET,
        SRC_STRIDE_3_LOW_OFFSET, DST_STRIDE_3_LOW_OFFSET, REPS_3_LOW_OFFSET
    };

    function automatic logic [31:0] write_data(input job_t job, input logic [3:0] idx);
        case (idx)
            4'd0:    return job.conf;
            4'd1:    return job.src_addr;
            4'd2:    return job.dst_addr;
            4'd3:    return job.length;
            4'd4:    return job.src_stride_2;
            4'd5:    return job.dst_stride_2;
            4'd6:    return job.reps_2;
            4'd7:    return job.src_stride_3;
            4'd8:    return job.dst_stride_3;
            4'd9:    return job.reps_3;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] stream_addr(input logic [31:0] base, input logic [3:0] stream);
        return base + {26'd0, stream, 2'b00};
    endfunction

endpackage

// File: rtl/idma_reg32_3d_launcher.sv
// Programs one 3-D job into an idma_reg32_3d frontend, launches it via next_id
// and optionally polls done_id until the transfer retires.
module idma_reg32_3d_launcher
    import idma_reg32_3d_launcher_pkg::*;
#(
    parameter int unsigned NumStreams = 1,
    parameter int unsigned PollGap    = 8,
    parameter type         reg_req_t  = reg32_req_t,
    parameter type         reg_rsp_t  = reg32_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  job_t     job_i,
    input  logic     job_valid_i,
    output logic     job_ready_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output res_t     res_o,
    output logic     res_valid_o,
    input  logic     res_ready_i,
    output logic     busy_o
);

    localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(PollGap - 1);

    state_t          state_q, state_d;
    job_t            job_q, job_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [31:0]     id_q, id_d;
    reg_req_t        req_q, req_d;
    res_t            res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic            job_ready_q;
    logic            busy_q;

    logic        req_hs;
    logic [31:0] poll_diff;

    assign req_hs    = req_q.valid && reg_rsp_i.ready;
    // Wrap-safe "done_id has reached id": sign of the 32-bit difference.
    assign poll_diff = reg_rsp_i.rdata - id_q;

    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        id_d        = id_q;
        req_d       = req_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (job_valid_i && job_ready_q) begin
                    job_d = job_i;
                    if (32'(job_i.stream) >= NumStreams) begin
                        state_d     = ST_RESULT;
                        res_d.id    = '0;
                        res_d.err   = 1'b1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d     = ST_WRITE;
                        cnt_d       = 4'd0;
                        req_d       = '0;
                        req_d.addr  = WriteSeq[0];
                        req_d.write = 1'b1;
                        req_d.wdata = write_data(job_i, 4'd0);
                        req_d.wstrb = 4'hF;
                        req_d.valid = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (req_hs) begin
                    if (reg_rsp_i.error) begin
                        state_d     = ST_RESULT;
                        req_d       = '0;
                        res_d.id    = '0;
                        res_d.err   = 1'b1;
                        res_valid_d = 1'b1;
                    end else if (cnt_q == 4'(NumWrites - 1)) begin
                        state_d     = ST_LAUNCH;
                        req_d       = '0;
                        req_d.addr  = stream_addr(NEXT_ID_0_OFFSET, job_q.stream);
                        req_d.valid = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + 4'd1;
                        req_d.addr  = WriteSeq[cnt_q + 4'd1];
                        req_d.wdata = write_data(job_q, cnt_q + 4'd1);
                    end
                end
            end
            ST_LAUNCH: begin
                if (req_hs) begin
                    req_d = '0;
                    if (reg_rsp_i.error) begin
                        state_d     = ST_RESULT;
                        res_d.id    = '0;
                        res_d.err   = 1'b1;
                        res_valid_d = 1'b1;
                    end else if (job_q.wait_done) begin
                        id_d    = reg_rsp_i.rdata;
                        state_d = ST_POLL_GAP;
                        gap_d   = GapLoad;
                    end else begin
                        id_d        = reg_rsp_i.rdata;
                        state_d     = ST_RESULT;
                        res_d.id    = reg_rsp_i.rdata;
                        res_d.err   = 1'b0;
                        res_valid_d = 1'b1;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_q == '0) begin
                    state_d     = ST_POLL;
                    req_d       = '0;
                    req_d.addr  = stream_addr(DONE_ID_0_OFFSET, job_q.stream);
                    req_d.valid = 1'b1;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            ST_POLL: begin
                if (req_hs) begin
                    req_d = '0;
                    if (reg_rsp_i.error || !poll_diff[31]) begin
                        state_d     = ST_RESULT;
                        res_d.id    = id_q;
                        res_d.err   = reg_rsp_i.error;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d = ST_POLL_GAP;
                        gap_d   = GapLoad;
                    end
                end
            end
            ST_RESULT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            job_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            id_q        <= '0;
            req_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            id_q        <= id_d;
            req_q       <= req_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            job_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign job_ready_o = job_ready_q;
    assign reg_req_o   = req_q;
    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_idma_reg32_3d_launcher.sv
// Directed bench for idma_reg32_3d_launcher with a behavioural register slave.
module tb_idma_reg32_3d_launcher;
    import idma_reg32_3d_launcher_pkg::*;

    localparam int NS = 2;
    localparam int PG = 4;
    localparam logic [31:0] EXP_ADDR [10] = '{
        32'h000, 32'h0D8, 32'h0D0, 32'h0E0, 32'h0F0,
        32'h0E8, 32'h0F8, 32'h108, 32'h100, 32'h110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    job_t       job = '0;
    logic       job_valid = 1'b0;
    logic       job_ready;
    reg32_req_t req;
    reg32_rsp_t rsp = '0;
    res_t       res;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic       busy;

    always #5 clk = ~clk;

    idma_reg32_3d_launcher #(
        .NumStreams(NS),
        .PollGap   (PG),
        .reg_req_t (reg32_req_t),
        .reg_rsp_t (reg32_rsp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .job_i      (job),
        .job_valid_i(job_valid),
        .job_ready_o(job_ready),
        .reg_req_o  (req),
        .reg_rsp_i  (rsp),
        .res_o      (res),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .busy_o     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] done_q[$];
    logic [31:0] next_id_val = 32'h0;
    int          rdy_mode = 0;
    int          err_at = -1;
    bit          err_poll = 1'b0;
    int          wr_count = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          rise_cyc = 0;
    int          stable_viol = 0;
    int          valid_cycles = 0;
    reg32_req_t  prev_req = '0;
    bit          prev_pend = 1'b0;
    bit          rv_prev = 1'b0;

    // Bus monitor: samples pre-edge values at every rising edge.
    always @(posedge clk) begin
        txn_t t;
        if (!rst) begin
            if (prev_pend && (req !== prev_req)) stable_viol++;
            if (req.valid) valid_cycles++;
            if (req.valid && rsp.ready) begin
                t.addr = req.addr; t.write = req.write; t.wdata = req.wdata;
                t.wstrb = req.wstrb; t.cyc = cyc;
                log_q.push_back(t);
                if (req.write) wr_count++;
                else if (req.addr >= 32'h84 && done_q.size() > 0) void'(done_q.pop_front());
            end
            if (job_valid && job_ready) accept_cyc = cyc;
            if (res_valid && !rv_prev) rise_cyc = cyc;
        end
        prev_pend = !rst && req.valid && !rsp.ready;
        prev_req  = req;
        rv_prev   = res_valid;
        cyc++;
    end

    // Register slave responder, driven mid-cycle.
    always @(negedge clk) begin
        rsp.ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp.error = 1'b0;
        rsp.rdata = '0;
        if (req.valid && req.write && wr_count == err_at) rsp.error = 1'b1;
        if (req.valid && !req.write) begin
            if (req.addr >= 32'h84) begin
                rsp.rdata = (done_q.size() > 0) ? done_q[0] : 32'hDEAD_BEEF;
                rsp.error = err_poll;
            end else begin
                rsp.rdata = next_id_val;
            end
        end
    end

    function automatic job_t mk_job(input logic [31:0] src, input logic [31:0] dst,
                                    input logic [31:0] len, input logic [3:0] stream,
                                    input logic wd);
        job_t j;
        j.conf = 32'h0000_0003; j.src_addr = src; j.dst_addr = dst; j.length = len;
        j.src_stride_2 = 32'h40; j.dst_stride_2 = 32'h80; j.reps_2 = 32'd2;
        j.src_stride_3 = 32'h400; j.dst_stride_3 = 32'h800; j.reps_3 = 32'd3;
        j.stream = stream; j.wait_done = wd;
        return j;
    endfunction

    task automatic send_job(input job_t j);
        int n = 0;
        @(negedge clk);
        job = j; job_valid = 1'b1;
        while (!job_ready && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (!job_ready) begin
            n_fail++; $display("FAIL job_accept: job_ready=%b required 1", job_ready);
            job_valid = 1'b0;
        end else begin
            @(posedge clk); #1 job_valid = 1'b0;
        end
    endtask

    task automatic wait_result(output res_t r);
        int n = 0;
        while (!res_valid && n < 2000) begin @(negedge clk); n++; end
        n_checks++;
        if (!res_valid) begin
            n_fail++; $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
        end
        r = res;
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        log_q.delete(); done_q.delete(); wr_count = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req !== '0) begin n_fail++; $display("FAIL reset_req: got %h required 0", req); end
        n_checks++;
        if (res !== '0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_res: got res=%h valid=%b required 0/0", res, res_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b required 1", job_ready); end
    endtask

    task automatic test_basic();
        job_t j; res_t r; logic [31:0] ed [10]; int e;
        clear_log(); rdy_mode = 0; next_id_val = 32'd5;
        j = mk_job(32'h1000, 32'h2000, 32'd64, 4'd0, 1'b0);
        ed = '{j.conf, j.src_addr, j.dst_addr, j.length, j.src_stride_2, j.dst_stride_2,
               j.reps_2, j.src_stride_3, j.dst_stride_3, j.reps_3};
        send_job(j);
        wait_result(r);
        n_checks++;
        if (log_q.size() != 11) begin n_fail++; $display("FAIL basic_count: got %0d txns required 11", log_q.size()); end
        else begin
            e = 0;
            for (int k = 0; k < 10; k++)
                if (log_q[k].addr !== EXP_ADDR[k] || log_q[k].wdata !== ed[k] || log_q[k].write !== 1'b1 ||
                    log_q[k].wstrb !== 4'hF || log_q[k].cyc != accept_cyc + 1 + k) begin
                    e++; $display("FAIL basic_write%0d: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                                  k, log_q[k].addr, log_q[k].wdata, log_q[k].cyc - accept_cyc, EXP_ADDR[k], ed[k], 1 + k);
                end
            n_checks++; if (e != 0) n_fail++;
            n_checks++;
            if (log_q[10].addr !== 32'h44 || log_q[10].write !== 1'b0 || log_q[10].cyc != accept_cyc + 11) begin
                n_fail++; $display("FAIL basic_launch: got addr=%h write=%b cyc=%0d required 44/0/11",
                                   log_q[10].addr, log_q[10].write, log_q[10].cyc - accept_cyc);
            end
        end
        n_checks++;
        if (rise_cyc != accept_cyc + 12) begin
            n_fail++; $display("FAIL basic_latency: res_valid at cycle %0d required 12", rise_cyc - accept_cyc);
        end
        n_checks++;
        if (r.id !== 32'd5 || r.err !== 1'b0) begin n_fail++; $display("FAIL basic_result: got id=%h err=%b required 5/0", r.id, r.err); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_idle: busy=%b job_ready=%b required 0/1", busy, job_ready);
        end
    endtask

    task automatic test_backpressure();
        job_t j; res_t r; logic [31:0] ed [10]; int e;
        clear_log(); rdy_mode = 1; next_id_val = 32'h77; stable_viol = 0;
        j = mk_job(32'hA000_0010, 32'hB000_0020, 32'd4096, 4'd1, 1'b0);
        j.conf = 32'h0000_000C; j.reps_3 = 32'd9;
        ed = '{j.conf, j.src_addr, j.dst_addr, j.length, j.src_stride_2, j.dst_stride_2,
               j.reps_2, j.src_stride_3, j.dst_stride_3, j.reps_3};
        send_job(j);
        wait_result(r);
        rdy_mode = 0;
        n_checks++;
        if (log_q.size() != 11) begin n_fail++; $display("FAIL bp_count: got %0d txns required 11", log_q.size()); end
        else begin
            e = 0;
            for (int k = 0; k < 10; k++)
                if (log_q[k].addr !== EXP_ADDR[k] || log_q[k].wdata !== ed[k]) begin
                    e++; $display("FAIL bp_write%0d: got addr=%h data=%h required addr=%h data=%h",
                                  k, log_q[k].addr, log_q[k].wdata, EXP_ADDR[k], ed[k]);
                end
            n_checks++; if (e != 0) n_fail++;
            n_checks++;
            if (log_q[10].addr !== 32'h48 || log_q[10].write !== 1'b0) begin
                n_fail++; $display("FAIL bp_launch: got addr=%h required 48", log_q[10].addr);
            end
        end
        n_checks++;
        if (stable_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stable_viol); end
        n_checks++;
        if (r.id !== 32'h77 || r.err !== 1'b0) begin n_fail++; $display("FAIL bp_result: got id=%h err=%b required 77/0", r.id, r.err); end
    endtask

    task automatic test_wait_done();
        res_t r;
        clear_log(); next_id_val = 32'h1;
        done_q.push_back(32'hFFFF_FFFF); done_q.push_back(32'h0); done_q.push_back(32'h1);
        send_job(mk_job(32'h3000, 32'h4000, 32'd128, 4'd0, 1'b1));
        wait_result(r);
        n_checks++;
        if (log_q.size() != 14) begin n_fail++; $display("FAIL wd_count: got %0d txns required 14", log_q.size()); end
        else begin
            for (int k = 11; k < 14; k++) begin
                n_checks++;
                if (log_q[k].addr !== 32'h84 || log_q[k].write !== 1'b0 || log_q[k].cyc - log_q[k-1].cyc != PG + 1) begin
                    n_fail++; $display("FAIL wd_poll%0d: got addr=%h gap=%0d required 84/%0d",
                                       k - 11, log_q[k].addr, log_q[k].cyc - log_q[k-1].cyc, PG + 1);
                end
            end
        end
        n_checks++;
        if (r.id !== 32'h1 || r.err !== 1'b0) begin n_fail++; $display("FAIL wd_result: got id=%h err=%b required 1/0", r.id, r.err); end
    endtask

    task automatic test_errors();
        res_t r; int vc;
        clear_log(); err_at = 3; next_id_val = 32'h9;
        send_job(mk_job(32'h5000, 32'h6000, 32'd32, 4'd0, 1'b0));
        wait_result(r);
        err_at = -1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (log_q.size() != 4) begin n_fail++; $display("FAIL werr_count: got %0d txns required 4", log_q.size()); end
        n_checks++;
        if (r.id !== 32'h0 || r.err !== 1'b1) begin n_fail++; $display("FAIL werr_result: got id=%h err=%b required 0/1", r.id, r.err); end

        clear_log(); vc = valid_cycles;
        send_job(mk_job(32'h5000, 32'h6000, 32'd32, 4'(NS), 1'b0));
        wait_result(r);
        n_checks++;
        if (valid_cycles != vc || log_q.size() != 0) begin
            n_fail++; $display("FAIL stream_bus: got %0d request cycles required 0", valid_cycles - vc);
        end
        n_checks++;
        if (r.id !== 32'h0 || r.err !== 1'b1) begin n_fail++; $display("FAIL stream_result: got id=%h err=%b required 0/1", r.id, r.err); end

        clear_log(); err_poll = 1'b1; next_id_val = 32'h9; done_q.push_back(32'h5);
        send_job(mk_job(32'h5000, 32'h6000, 32'd32, 4'd1, 1'b1));
        wait_result(r);
        err_poll = 1'b0;
        n_checks++;
        if (r.id !== 32'h9 || r.err !== 1'b1 || log_q.size() != 12) begin
            n_fail++; $display("FAIL perr_result: got id=%h err=%b txns=%0d required 9/1/12", r.id, r.err, log_q.size());
        end
    endtask

    task automatic test_result_stall();
        res_t r; int vc; int viol = 0; int n = 0;
        clear_log(); next_id_val = 32'h33; res_ready = 1'b0;
        send_job(mk_job(32'h7000, 32'h8000, 32'd16, 4'd0, 1'b0));
        while (!res_valid && n < 200) begin @(negedge clk); n++; end
        r = res; vc = valid_cycles;
        job = mk_job(32'h1, 32'h2, 32'd3, 4'd0, 1'b0); job_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res !== r || job_ready !== 1'b0 || busy !== 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles required 0", viol); end
        n_checks++;
        if (valid_cycles != vc) begin n_fail++; $display("FAIL stall_bus: got %0d request cycles required 0", valid_cycles - vc); end
        n_checks++;
        if (r.id !== 32'h33 || r.err !== 1'b0) begin n_fail++; $display("FAIL stall_result: got id=%h err=%b required 33/0", r.id, r.err); end
        job_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: res_valid=%b job_ready=%b required 0/1", res_valid, job_ready);
        end
    endtask

    task automatic test_reset_mid();
        int vc;
        clear_log(); next_id_val = 32'h44;
        send_job(mk_job(32'h9000, 32'hA000, 32'd8, 4'd0, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req.valid !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: valid=%b busy=%b res_valid=%b required 0/0/0", req.valid, busy, res_valid);
        end
        @(negedge clk); rst = 1'b0; vc = valid_cycles;
        repeat (15) @(negedge clk);
        n_checks++;
        if (valid_cycles != vc || res_valid !== 1'b0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_discard: req cycles=%0d res_valid=%b job_ready=%b required 0/0/1",
                               valid_cycles - vc, res_valid, job_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wait_done();
        test_errors();
        test_result_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
